// File: rtl/quiz_pkg.sv
// quiz_pkg: shared types and helpers for the arithmetic quiz round sequencer.
// Holds op codes, the sequencer state enum, verdict encodings and the
// saturating score / non-underflowing lives helpers.
package quiz_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ASK    = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RESULT = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    VERDICT_NONE    = 2'd0,
    VERDICT_CORRECT = 2'd1,
    VERDICT_WRONG   = 2'd2,
    VERDICT_TIMEOUT = 2'd3
  } verdict_t;

  // Add a small increment to the score, clamping at the configured maximum.
  function automatic logic [6:0] sat_add(input logic [6:0] base,
                                         input logic [1:0] inc,
                                         input logic [6:0] max_val);
    logic [7:0] sum;
    sum = {1'b0, base} + {6'b000000, inc};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end else begin
      return sum[6:0];
    end
  endfunction

  // Take one life away, never wrapping below zero.
  function automatic logic [1:0] lives_dec(input logic [1:0] cur);
    if (cur == 2'd0) begin
      return 2'd0;
    end else begin
      return cur - 2'd1;
    end
  endfunction

endpackage

// File: rtl/quiz_alu.sv
// quiz_alu: combinational expected-result unit.
// Decodes {num1, op, num2} and produces the 7-bit unsigned result. 'valid'
// drops for unknown ops or a zero operand, so such questions can never be
// answered correctly.
module quiz_alu
  import quiz_pkg::*;
(
  input  logic [11:0] expr,
  output logic [6:0]  result,
  output logic        valid
);

  logic [6:0] n1;
  logic [6:0] n2;
  logic [3:0] op;

  assign n1 = {3'b000, expr[11:8]};
  assign op = expr[7:4];
  assign n2 = {3'b000, expr[3:0]};

  // Evaluate the expression and qualify it.
  always_comb begin
    result = 7'd0;
    valid  = 1'b0;
    case (op)
      OP_ADD: begin
        result = n1 + n2;
        valid  = 1'b1;
      end
      OP_SUB: begin
        result = n1 - n2;
        valid  = 1'b1;
      end
      OP_MUL: begin
        result = n1 * n2;
        valid  = 1'b1;
      end
      OP_DIV: begin
        // Zero divisor is already judged invalid below; keep the divider defined.
        if (n2 != 7'd0) begin
          result = n1 / n2;
        end else begin
          result = 7'd0;
        end
        valid = 1'b1;
      end
      default: begin
        result = 7'd0;
        valid  = 1'b0;
      end
    endcase
    if ((n1 == 7'd0) || (n2 == 7'd0)) begin
      valid = 1'b0;
    end else begin
      valid = valid;
    end
  end

endmodule

// File: rtl/quiz_ctrl.sv
// quiz_ctrl: round sequencer for the arithmetic quiz game.
// Latches one expression per round, counts down the answer window, judges
// the answer against quiz_alu and maintains score / lives.
// Optional feature macro: QUIZ_STREAK_BONUS_EN -- every third consecutive
// correct answer scores +2 instead of +1.
module quiz_ctrl
  import quiz_pkg::*;
#(
  parameter logic [15:0] TIME_LIMIT  = 16'd5000,
  parameter logic [7:0]  RESULT_HOLD = 8'd50,
  parameter logic [1:0]  LIVES       = 2'd3,
  parameter logic [6:0]  SCORE_MAX   = 7'd99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] exp_in,
  input  logic [1:0]  line_in,
  input  logic [6:0]  ans,
  input  logic        ans_valid,
  output logic [6:0]  score,
  output logic [11:0] q_exp,
  output logic [1:0]  q_line,
  output logic [15:0] time_left,
  output logic [1:0]  lives,
  output logic [1:0]  verdict,
  output logic        game_over
);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [6:0] ans_latched;
  logic [6:0] alu_result;
  logic       alu_valid;
`ifdef QUIZ_STREAK_BONUS_EN
  logic [1:0] streak;
`endif

  quiz_alu u_alu (
    .expr   (q_exp),
    .result (alu_result),
    .valid  (alu_valid)
  );

  // Round sequencer: state, countdown, judging and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      score       <= 7'd0;
      q_exp       <= 12'd0;
      q_line      <= 2'd0;
      time_left   <= 16'd0;
      lives       <= 2'd0;
      verdict     <= VERDICT_NONE;
      game_over   <= 1'b0;
      hold_cnt    <= 8'd0;
      ans_latched <= 7'd0;
`ifdef QUIZ_STREAK_BONUS_EN
      streak      <= 2'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state     <= ST_LOAD;
            score     <= 7'd0;
            lives     <= LIVES;
            game_over <= 1'b0;
`ifdef QUIZ_STREAK_BONUS_EN
            streak    <= 2'd0;
`endif
          end else begin
            state <= state;
          end
        end
        ST_LOAD: begin
          q_exp     <= exp_in;
          q_line    <= line_in;
          time_left <= TIME_LIMIT;
          verdict   <= VERDICT_NONE;
          state     <= ST_ASK;
        end
        ST_ASK: begin
          // A strobe on the last countdown cycle still counts as an answer.
          if (ans_valid) begin
            ans_latched <= ans;
            time_left   <= 16'd0;
            state       <= ST_CHECK;
          end else if (time_left <= 16'd1) begin
            time_left <= 16'd0;
            verdict   <= VERDICT_TIMEOUT;
            lives     <= lives_dec(lives);
            hold_cnt  <= RESULT_HOLD - 8'd1;
            state     <= ST_RESULT;
`ifdef QUIZ_STREAK_BONUS_EN
            streak    <= 2'd0;
`endif
          end else begin
            time_left <= time_left - 16'd1;
          end
        end
        ST_CHECK: begin
          if (alu_valid && (ans_latched == alu_result)) begin
            verdict <= VERDICT_CORRECT;
`ifdef QUIZ_STREAK_BONUS_EN
            if (streak == 2'd2) begin
              score  <= sat_add(score, 2'd2, SCORE_MAX);
              streak <= 2'd0;
            end else begin
              score  <= sat_add(score, 2'd1, SCORE_MAX);
              streak <= streak + 2'd1;
            end
`else
            score <= sat_add(score, 2'd1, SCORE_MAX);
`endif
          end else begin
            verdict <= VERDICT_WRONG;
            lives   <= lives_dec(lives);
`ifdef QUIZ_STREAK_BONUS_EN
            streak  <= 2'd0;
`endif
          end
          hold_cnt <= RESULT_HOLD - 8'd1;
          state    <= ST_RESULT;
        end
        ST_RESULT: begin
          if (hold_cnt == 8'd0) begin
            if (lives == 2'd0) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_ctrl.sv
// tb_quiz_ctrl: directed vectors for quiz_ctrl with a scoreboard.
// Each answered/timed-out round pushes the expected {verdict, score, lives};
// a monitor pops and compares whenever a fresh verdict appears.
module tb_quiz_ctrl;

  localparam logic [15:0] TL = 16'd20;
  localparam logic [7:0]  RH = 8'd4;
  localparam logic [1:0]  LV = 2'd3;
  localparam logic [6:0]  SM = 7'd99;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] exp_in;
  logic [1:0]  line_in;
  logic [6:0]  ans;
  logic        ans_valid;
  logic [6:0]  score;
  logic [11:0] q_exp;
  logic [1:0]  q_line;
  logic [15:0] time_left;
  logic [1:0]  lives;
  logic [1:0]  verdict;
  logic        game_over;

  quiz_ctrl #(
    .TIME_LIMIT  (TL),
    .RESULT_HOLD (RH),
    .LIVES       (LV),
    .SCORE_MAX   (SM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .exp_in    (exp_in),
    .line_in   (line_in),
    .ans       (ans),
    .ans_valid (ans_valid),
    .score     (score),
    .q_exp     (q_exp),
    .q_line    (q_line),
    .time_left (time_left),
    .lives     (lives),
    .verdict   (verdict),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int s;
    int l;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   m_score = 0;
  int   m_lives = 0;
  int   m_streak = 0;
  logic [1:0] prev_v = 2'd0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: apply a verdict to score/lives and queue the expectation.
  task automatic push_exp(input int v);
    int inc;
    inc = 1;
    if (v == 1) begin
`ifdef QUIZ_STREAK_BONUS_EN
      if (m_streak == 2) begin
        inc = 2;
        m_streak = 0;
      end else begin
        m_streak++;
      end
`endif
      m_score = (m_score + inc > 99) ? 99 : m_score + inc;
    end else begin
      if (m_lives > 0) m_lives--;
      m_streak = 0;
    end
    sbq.push_back('{v, m_score, m_lives});
  endtask

  // Monitor: every fresh verdict is checked against the head of the queue.
  always @(negedge clk) begin
    if (verdict != 2'd0 && prev_v == 2'd0) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=%0d required=none", verdict);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_verdict", int'(verdict), mon_e.v);
        chk("sb_score", int'(score), mon_e.s);
        chk("sb_lives", int'(lives), mon_e.l);
      end
    end
    prev_v <= verdict;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_q_exp"}, int'(q_exp), 0);
    chk({tag, "_q_line"}, int'(q_line), 0);
    chk({tag, "_time_left"}, int'(time_left), 0);
    chk({tag, "_lives"}, int'(lives), 0);
    chk({tag, "_verdict"}, int'(verdict), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  task automatic start_game(input logic [11:0] e);
    exp_in = e;
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0;
    m_lives = 3;
    m_streak = 0;
  endtask

  task automatic wait_ask();
    int n;
    n = 0;
    while (time_left != TL && n < 100) begin
      step();
      n++;
    end
    chk("ask_reached", int'(time_left), int'(TL));
  endtask

  task automatic do_round(input logic [11:0] e, input logic [6:0] a, input int v);
    exp_in = e;
    wait_ask();
    chk("q_exp_latched", int'(q_exp), int'(e));
    push_exp(v);
    ans = a;
    ans_valid = 1'b1;
    step();
    ans_valid = 1'b0;
    step();
  endtask

  task automatic do_timeout(input bit poke_start);
    int n;
    wait_ask();
    push_exp(3);
    n = 0;
    while (verdict == 2'd0 && n < 2 * int'(TL)) begin
      if (poke_start && n == 0) start = 1'b1;
      step();
      start = 1'b0;
      n++;
      if (poke_start && n == 2) chk("start_ignored_tl", int'(time_left), int'(TL) - 2);
    end
    chk("timeout_latency", n, int'(TL));
  endtask

  task automatic do_coincident(input logic [11:0] e, input logic [6:0] a);
    int n;
    exp_in = e;
    wait_ask();
    n = 0;
    while (time_left != 16'd1 && n < 2 * int'(TL)) begin
      step();
      n++;
    end
    chk("reach_tl1", int'(time_left), 1);
    push_exp(1);
    ans = a;
    ans_valid = 1'b1;
    step();
    ans_valid = 1'b0;
    step();
    chk("coincident_verdict", int'(verdict), 1);
  endtask

  task automatic wait_over(input string tag);
    int n;
    n = 0;
    while (!game_over && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_game_over"}, int'(game_over), 1);
    chk({tag, "_time_left"}, int'(time_left), 0);
    chk({tag, "_lives"}, int'(lives), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    exp_in = 12'd0;
    line_in = 2'd0;
    ans = 7'd0;
    ans_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset("reset");

    // Game 1: mixed correct / wrong answers until lives run out.
    line_in = 2'd2;
    start_game(12'h3A5);
    chk("lives_at_start", int'(lives), 3);
    chk("q_exp_before_load", int'(q_exp), 0);
    step();
    chk("q_exp_2nd_edge", int'(q_exp), 12'h3A5);
    chk("q_line_2nd_edge", int'(q_line), 2);
    chk("time_left_ask_entry", int'(time_left), int'(TL));
    do_round(12'h3A5, 7'd8, 1);   // 3+5=8
    do_round(12'h9D2, 7'd4, 1);   // 9/2=4
    do_round(12'h9D2, 7'd5, 2);   // wrong
    do_round(12'h7E3, 7'd0, 2);   // illegal op
    do_round(12'h5B2, 7'd3, 1);   // 5-2=3
    do_round(12'h4C3, 7'd12, 1);  // 4*3=12
    do_round(12'h0A5, 7'd5, 2);   // zero operand
    wait_over("game1");
    chk("game1_score", int'(score), m_score);

    // Game 2: timeouts, start ignored in ASK, coincident answer.
    start_game(12'h2A2);
    do_timeout(1'b1);
    do_coincident(12'h2A2, 7'd4);
    do_timeout(1'b0);
    do_timeout(1'b0);
    wait_over("game2");

    // Game 3: saturate the score, then reset in the middle of RESULT.
    start_game(12'h1A1);
    for (int i = 0; i < 100; i++) begin
      do_round(12'h1A1, 7'd2, 1);
    end
    chk("score_saturated", int'(score), 99);
    wait_ask();
    push_exp(1);
    ans = 7'd2;
    ans_valid = 1'b1;
    step();
    ans_valid = 1'b0;
    step();
    step();
    chk("mid_result_score", int'(score), 99);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("mid_reset");

    // Game 4: illegal op after reset is always wrong.
    start_game(12'h7E3);
    do_round(12'h7E3, 7'd21, 2);
    step();
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
